// File: rtl/barret_pkg.sv
// Shared constants and helpers for the pipelined Barrett reducer.
// Optional tag sideband is enabled by defining BARRETT_TAG_EN.
package barret_pkg;

    // Default moduli used across the Galois datapath
    localparam int Q_2417 = 2417;
    localparam int K_2417 = 12;
    localparam int Q_3329 = 3329;
    localparam int K_3329 = 12;

    // Width helpers for the default instance
    localparam int MU_W = K_2417 + 2;
    localparam int R_W  = K_2417 + 2;

    // Width of MU = floor(2^(2k)/q) when 2^(k-1) < q < 2^k
    function automatic int mu_width(input int k);
        return k + 2;
    endfunction

    // Width of the partially reduced remainder, which lies in [0, 4q)
    function automatic int r_width(input int k);
        return k + 2;
    endfunction

    // Barrett constant MU = floor(2^(2k)/q), evaluated at elaboration
    function automatic longint unsigned calc_mu(input longint unsigned q, input int k);
        return (64'd1 << (2 * k)) / q;
    endfunction

endpackage

// File: rtl/barret_corr.sv
// Final correction: up to three conditional subtractions of Q that bring
// a (K+2)-bit partial remainder in [0, 4Q) down to a K-bit value < Q.
module barret_corr
    import barret_pkg::*;
#(
    parameter int Q = 2417,
    parameter int K = 12
)(
    input  logic [K+1:0] r_in,
    output logic [K-1:0] r_out
);

    localparam logic [K+1:0] QR = (K+2)'(Q);

    logic [K+1:0] s1_s;
    logic [K+1:0] s2_s;

    // Three chained compare-and-subtract steps; the last step can only leave a value below Q
    always_comb begin
        s1_s  = (r_in >= QR) ? (r_in - QR) : r_in;
        s2_s  = (s1_s >= QR) ? (s1_s - QR) : s1_s;
        r_out = (s2_s >= QR) ? K'(s2_s - QR) : s2_s[K-1:0];
    end

endmodule

// File: rtl/barret_pipe.sv
// Three-stage pipelined Barrett reducer: dout_r = din_a mod Q, valid/ready
// on both sides, one result per cycle, bubbles collapse under back-pressure.
// Define BARRETT_TAG_EN to carry a TAG_W-bit tag alongside each operand.
module barret_pipe
    import barret_pkg::*;
#(
    parameter int Q     = 2417,
    parameter int K     = 12,
    parameter int TAG_W = 4
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic [2*K-1:0]   din_a,
`ifdef BARRETT_TAG_EN
    input  logic [TAG_W-1:0] din_tag,
`endif
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic [K-1:0]     dout_r
`ifdef BARRETT_TAG_EN
    ,
    output logic [TAG_W-1:0] dout_tag
`endif
);

    localparam int MUW = mu_width(K);
    localparam int RW  = r_width(K);
    localparam int PW  = 2 * K + 2;
    localparam logic [MUW-1:0] MU = MUW'(calc_mu(64'(Q), K));
    localparam logic [RW-1:0]  QR = RW'(Q);

    // Reject parameter sets for which the Barrett bounds do not hold
    if ((Q <= (1 << (K - 1))) || (Q >= (1 << K)) || (TAG_W < 1)) begin : g_bad_params
        $error("barret_pipe: require 2^(K-1) < Q < 2^K and TAG_W >= 1");
    end

    logic          ld1_s;
    logic          ld2_s;
    logic          ld3_s;
    logic [RW-1:0] t_s;
    logic [RW-1:0] tq_s;
    logic [RW-1:0] r0_s;
    logic [K-1:0]  corr_s;

    // Stage 1 keeps only t = p >> K and the low RW bits of x; the other bits
    // of p and x cannot affect r0 = (x - t*Q) mod 2^RW.
    logic          v1_r;
    logic          v2_r;
    logic [RW-1:0] t_r;
    logic [RW-1:0] x_r;
    logic [RW-1:0] r0_r;

    // Load enables ripple back from the output so a stall or bubble is seen in the same cycle
    always_comb begin
        ld3_s     = ~dout_valid | dout_ready;
        ld2_s     = ~v2_r | ld3_s;
        ld1_s     = ~v1_r | ld2_s;
        din_ready = ld1_s;
    end

    // Quotient estimate, Q multiple and raw remainder (all arithmetic mod 2^RW past stage 1)
    always_comb begin
        t_s  = RW'((PW'(din_a[2*K-1:K]) * PW'(MU)) >> K);
        tq_s = t_r * QR;
        r0_s = x_r - tq_s;
    end

    barret_corr #(
        .Q (Q),
        .K (K)
    ) u_corr (
        .r_in  (r0_r),
        .r_out (corr_s)
    );

    // Pipeline valid bits and data registers; data moves only with a valid operand
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_r       <= 1'b0;
            v2_r       <= 1'b0;
            dout_valid <= 1'b0;
            t_r        <= '0;
            x_r        <= '0;
            r0_r       <= '0;
            dout_r     <= '0;
        end else begin
            if (ld1_s) begin
                v1_r <= din_valid;
                if (din_valid) begin
                    t_r <= t_s;
                    x_r <= din_a[RW-1:0];
                end
            end
            if (ld2_s) begin
                v2_r <= v1_r;
                if (v1_r) begin
                    r0_r <= r0_s;
                end
            end
            if (ld3_s) begin
                dout_valid <= v2_r;
                if (v2_r) begin
                    dout_r <= corr_s;
                end
            end
        end
    end

`ifdef BARRETT_TAG_EN
    logic [TAG_W-1:0] tag1_r;
    logic [TAG_W-1:0] tag2_r;

    // Tag registers advance with the same enables as the data they describe
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tag1_r   <= '0;
            tag2_r   <= '0;
            dout_tag <= '0;
        end else begin
            if (ld1_s && din_valid) begin
                tag1_r <= din_tag;
            end
            if (ld2_s && v1_r) begin
                tag2_r <= tag1_r;
            end
            if (ld3_s && v2_r) begin
                dout_tag <= tag2_r;
            end
        end
    end
`endif

endmodule
